// File: rtl/dshot_pkg.sv
// dshot_pkg
// Shared definitions for the DShot transmitter:
//   frame_t       - 16-bit on-wire frame {throttle, telem, crc}
//   state_t       - transmitter FSM states
//   calc_bit_cyc  - clock cycles per DShot bit, rounded to nearest
//   calc_t1h      - active cycles for a '1' bit (3/4 of a bit period)
//   calc_t0h      - active cycles for a '0' bit (3/8 of a bit period)
//   dshot_crc     - 4-bit nibble-XOR checksum, optionally inverted
//   make_frame    - packs throttle/telem and appends the checksum
package dshot_pkg;

  typedef logic [15:0] frame_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  function automatic int calc_bit_cyc(input int clk_hz, input int bit_rate);
    return (clk_hz + bit_rate / 2) / bit_rate;
  endfunction

  function automatic int calc_t1h(input int bit_cyc);
    return bit_cyc * 3 / 4;
  endfunction

  function automatic int calc_t0h(input int bit_cyc);
    return bit_cyc * 3 / 8;
  endfunction

  // Bidirectional DShot uses the complemented checksum so the ESC can tell
  // which protocol variant it is receiving.
  function automatic logic [3:0] dshot_crc(input logic [11:0] v, input logic inverted);
    logic [11:0] x;
    x = v ^ (v >> 4) ^ (v >> 8);
    return inverted ? ~x[3:0] : x[3:0];
  endfunction

  function automatic frame_t make_frame(input logic [10:0] throttle,
                                        input logic        telem,
                                        input logic        inverted);
    logic [11:0] v;
    v = {throttle, telem};
    return {v, dshot_crc(v, inverted)};
  endfunction

endpackage

// File: rtl/dshot_bit_timer.sv
// dshot_bit_timer
// Times a single DShot bit: BIT_CYC cycles long, active for T1H cycles when
// the bit is 1 or T0H cycles when it is 0, inactive for the remainder.
// Ports:
//   CLK      - clock, rising edge
//   rst_n    - asynchronous active-low reset
//   start    - begin a new bit on the next cycle (first cycle is active)
//   bit_val  - value of the bit currently being timed
//   line     - registered line level, polarity per INVERTED
//   bit_end  - high on the last cycle of the current bit
module dshot_bit_timer #(
  parameter int BIT_CYC  = 27,
  parameter int T1H      = 20,
  parameter int T0H      = 10,
  parameter int INVERTED = 0
) (
  input  logic CLK,
  input  logic rst_n,
  input  logic start,
  input  logic bit_val,
  output logic line,
  output logic bit_end
);

  localparam int CW = $clog2(BIT_CYC + 1);
  localparam logic [CW-1:0] LAST  = CW'(BIT_CYC - 1);
  localparam logic [CW-1:0] T1H_W = CW'(T1H);
  localparam logic [CW-1:0] T0H_W = CW'(T0H);
  localparam logic          INV   = (INVERTED != 0);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic [CW-1:0] high_len;
  logic          running;
  logic          active;

  assign cnt_nxt  = cnt + 1'b1;
  assign high_len = bit_val ? T1H_W : T0H_W;

  // The level register always holds the value for the cycle it is visible
  // in, so it is computed from the count the cycle will have. A start that
  // coincides with bit_end chains the next bit without an idle cycle.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      running <= 1'b0;
      active  <= 1'b0;
      bit_end <= 1'b0;
    end else if (start) begin
      cnt     <= '0;
      running <= 1'b1;
      active  <= 1'b1;
      bit_end <= 1'b0;
    end else if (running) begin
      if (cnt == LAST) begin
        cnt     <= '0;
        running <= 1'b0;
        active  <= 1'b0;
        bit_end <= 1'b0;
      end else begin
        cnt     <= cnt_nxt;
        active  <= (cnt_nxt < high_len);
        bit_end <= (cnt_nxt == LAST);
      end
    end
  end

  // Polarity is a constant, so the output stays a clean register output.
  assign line = active ^ INV;

endmodule

// File: rtl/dshot_tx.sv
// dshot_tx
// DShot serial transmitter. Accepts a throttle/telemetry request, appends
// the checksum and sends the 16-bit frame MSB first, followed by an idle
// gap. Optionally inverted (bidirectional DShot) and optionally repeating
// the last frame when no new request arrives.
// Ports:
//   CLK        - clock, rising edge
//   rst_n      - asynchronous active-low reset
//   throttle   - 11-bit command/throttle value
//   telem      - telemetry request bit
//   valid      - request strobe, taken when ready is high
//   ready      - high while idle, request can be accepted
//   dshot_out  - serial DShot line
//   busy       - high during a frame or its trailing gap
//   frame_done - one-cycle pulse on the last cycle of bit 0
module dshot_tx
  import dshot_pkg::*;
#(
  parameter int CLK_HZ   = 16000000,
  parameter int BIT_RATE = 600000,
  parameter int GAP_CYC  = 64,
  parameter int INVERTED = 0,
  parameter int REPEAT   = 0
) (
  input  logic        CLK,
  input  logic        rst_n,
  input  logic [10:0] throttle,
  input  logic        telem,
  input  logic        valid,
  output logic        ready,
  output logic        dshot_out,
  output logic        busy,
  output logic        frame_done
);

  localparam int BIT_CYC = calc_bit_cyc(CLK_HZ, BIT_RATE);
  localparam int T1H     = calc_t1h(BIT_CYC);
  localparam int T0H     = calc_t0h(BIT_CYC);
  localparam int GW      = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYC - 1);
  localparam logic INV   = (INVERTED != 0);

  state_t        state;
  frame_t        frame_q;
  logic [3:0]    bit_idx;
  logic [GW-1:0] gap_cnt;

  logic accept;
  logic restart;
  logic last_bit;
  logic bit_end;
  logic bit_start;

  assign accept   = (state == ST_IDLE) && valid;
  assign last_bit = (bit_idx == 4'd0);
  // Repeat only when nobody is asking for a new frame; a pending request
  // drops back to IDLE so it is accepted the next cycle.
  assign restart  = (state == ST_GAP) && (gap_cnt == GAP_LAST) &&
                    (REPEAT != 0) && !valid;
  assign bit_start = accept || restart ||
                     ((state == ST_SEND) && bit_end && !last_bit);

  assign ready      = (state == ST_IDLE);
  assign busy       = (state != ST_IDLE);
  assign frame_done = (state == ST_SEND) && bit_end && last_bit;

  // Frame sequencing: IDLE -> SEND (bits 15..0) -> GAP -> IDLE, or back to
  // SEND with the held frame when repeating. The frame is captured only on
  // acceptance, so requests arriving while busy cannot disturb it.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      frame_q <= '0;
      bit_idx <= 4'd0;
      gap_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (valid) begin
            frame_q <= make_frame(throttle, telem, INV);
            bit_idx <= 4'd15;
            state   <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (bit_end) begin
            if (last_bit) begin
              gap_cnt <= '0;
              state   <= ST_GAP;
            end else begin
              bit_idx <= bit_idx - 4'd1;
            end
          end
        end
        ST_GAP: begin
          if (gap_cnt == GAP_LAST) begin
            gap_cnt <= '0;
            if (restart) begin
              bit_idx <= 4'd15;
              state   <= ST_SEND;
            end else begin
              state   <= ST_IDLE;
            end
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  dshot_bit_timer #(
    .BIT_CYC (BIT_CYC),
    .T1H     (T1H),
    .T0H     (T0H),
    .INVERTED(INVERTED)
  ) u_bit_timer (
    .CLK    (CLK),
    .rst_n  (rst_n),
    .start  (bit_start),
    .bit_val(frame_q[bit_idx]),
    .line   (dshot_out),
    .bit_end(bit_end)
  );

endmodule

// File: tb/tb_dshot_tx.sv
// tb_dshot_tx
// Self-checking bench for dshot_tx. Four instances cover the default,
// inverted, repeating and 150 kbit/s configurations. Line activity is
// captured cycle by cycle after each acceptance and compared against a
// reference waveform built from the frame arithmetic.
module tb_dshot_tx;

  localparam int GAP  = 64;
  localparam int BC_F = (16000000 + 600000 / 2) / 600000;
  localparam int T1_F = BC_F * 3 / 4;
  localparam int T0_F = BC_F * 3 / 8;
  localparam int BC_S = (16000000 + 150000 / 2) / 150000;
  localparam int T1_S = BC_S * 3 / 4;
  localparam int T0_S = BC_S * 3 / 8;
  localparam int NCAP = 4096;

  logic        clk = 1'b0;
  logic [3:0]  rst_v;
  logic [3:0]  valid_v;
  logic [3:0]  telem_v;
  logic [10:0] thr_v [4];
  wire  [3:0]  ready_v;
  wire  [3:0]  out_v;
  wire  [3:0]  busy_v;
  wire  [3:0]  done_v;

  int errors = 0;
  int checks = 0;

  bit cap_line  [NCAP];
  bit cap_busy  [NCAP];
  bit cap_done  [NCAP];
  bit cap_ready [NCAP];

  always #5 clk = ~clk;

  dshot_tx #(.CLK_HZ(16000000), .BIT_RATE(600000), .GAP_CYC(GAP), .INVERTED(0), .REPEAT(0)) u_std (
    .CLK(clk), .rst_n(rst_v[0]), .throttle(thr_v[0]), .telem(telem_v[0]), .valid(valid_v[0]),
    .ready(ready_v[0]), .dshot_out(out_v[0]), .busy(busy_v[0]), .frame_done(done_v[0]));

  dshot_tx #(.CLK_HZ(16000000), .BIT_RATE(600000), .GAP_CYC(GAP), .INVERTED(1), .REPEAT(0)) u_inv (
    .CLK(clk), .rst_n(rst_v[1]), .throttle(thr_v[1]), .telem(telem_v[1]), .valid(valid_v[1]),
    .ready(ready_v[1]), .dshot_out(out_v[1]), .busy(busy_v[1]), .frame_done(done_v[1]));

  dshot_tx #(.CLK_HZ(16000000), .BIT_RATE(600000), .GAP_CYC(GAP), .INVERTED(0), .REPEAT(1)) u_rep (
    .CLK(clk), .rst_n(rst_v[2]), .throttle(thr_v[2]), .telem(telem_v[2]), .valid(valid_v[2]),
    .ready(ready_v[2]), .dshot_out(out_v[2]), .busy(busy_v[2]), .frame_done(done_v[2]));

  dshot_tx #(.CLK_HZ(16000000), .BIT_RATE(150000), .GAP_CYC(GAP), .INVERTED(0), .REPEAT(0)) u_slow (
    .CLK(clk), .rst_n(rst_v[3]), .throttle(thr_v[3]), .telem(telem_v[3]), .valid(valid_v[3]),
    .ready(ready_v[3]), .dshot_out(out_v[3]), .busy(busy_v[3]), .frame_done(done_v[3]));

  function automatic int bc_of(input int i);
    return (i == 3) ? BC_S : BC_F;
  endfunction

  function automatic int t1_of(input int i);
    return (i == 3) ? T1_S : T1_F;
  endfunction

  function automatic int t0_of(input int i);
    return (i == 3) ? T0_S : T0_F;
  endfunction

  // Reference frame: 12-bit value times 16 plus the nibble checksum.
  function automatic logic [15:0] model_frame(input logic [10:0] t, input logic tel, input bit inv);
    int v;
    int c;
    v = int'(t) * 2 + int'(tel);
    c = (v ^ (v >> 4) ^ (v >> 8)) % 16;
    if (inv) c = 15 - c;
    return 16'(v * 16 + c);
  endfunction

  // Active/inactive for cycle k counted from the first cycle of bit 15.
  function automatic bit model_active(input logic [15:0] f, input int k, input int bc,
                                      input int t1, input int t0);
    int b;
    int pos;
    if (k < 0 || k >= 16 * bc) return 1'b0;
    b   = 15 - k / bc;
    pos = k % bc;
    return pos < (f[b] ? t1 : t0);
  endfunction

  // Presents a request, then records outputs for ncyc cycles; sample k=0 is
  // the first cycle after the acceptance edge. valid stays high for 'hold'
  // cycles after acceptance with throttle switched to t_late.
  task automatic capture(input int i, input logic [10:0] t, input logic tel,
                         input logic [10:0] t_late, input int hold, input int ncyc);
    @(negedge clk);
    thr_v[i]   = t;
    telem_v[i] = tel;
    valid_v[i] = 1'b1;
    for (int k = 0; k < ncyc; k++) begin
      @(negedge clk);
      cap_line[k]  = out_v[i];
      cap_busy[k]  = busy_v[i];
      cap_done[k]  = done_v[i];
      cap_ready[k] = ready_v[i];
      if (k == 0) thr_v[i] = t_late;
      if (k >= hold) valid_v[i] = 1'b0;
    end
    valid_v[i] = 1'b0;
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (out_v[i] !== (i == 1)) begin
        errors++;
        $display("[TB] FAIL reset_line dut=%0d got %b expected %b", i, out_v[i], (i == 1));
      end
      checks++;
      if (busy_v[i] !== 1'b0 || done_v[i] !== 1'b0) begin
        errors++;
        $display("[TB] FAIL reset_busy_done dut=%0d got busy=%b done=%b expected 0/0", i, busy_v[i], done_v[i]);
      end
    end
    rst_v = 4'hF;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (ready_v[i] !== 1'b1 || busy_v[i] !== 1'b0) begin
        errors++;
        $display("[TB] FAIL reset_release dut=%0d got ready=%b busy=%b expected 1/0", i, ready_v[i], busy_v[i]);
      end
    end
  endtask

  task automatic test_frame(input int i, input logic [10:0] t, input logic tel);
    int bc, t1, t0, flen, ncyc, bad, w, rise, ndone, done_at, blen, rdy_bad;
    bit inv;
    logic [15:0] expf;
    logic [15:0] got;
    bc   = bc_of(i);
    t1   = t1_of(i);
    t0   = t0_of(i);
    inv  = (i == 1);
    expf = model_frame(t, tel, inv);
    flen = 16 * bc;
    ncyc = flen + GAP + 8;
    checks++;
    if (ready_v[i] !== 1'b1) begin
      errors++;
      $display("[TB] FAIL ready_before dut=%0d got %b expected 1", i, ready_v[i]);
    end
    capture(i, t, tel, t, 0, ncyc);
    bad = -1;
    for (int k = 0; k < ncyc; k++)
      if (cap_line[k] !== (model_active(expf, k, bc, t1, t0) ^ inv) && bad < 0) bad = k;
    checks++;
    if (bad >= 0) begin
      errors++;
      $display("[TB] FAIL waveform dut=%0d frame %h cycle %0d got %b expected %b",
               i, expf, bad, cap_line[bad], model_active(expf, bad, bc, t1, t0) ^ inv);
    end
    got = '0;
    for (int b = 0; b < 16; b++) begin
      w = 0;
      for (int c = 0; c < bc; c++)
        if ((cap_line[(15 - b) * bc + c] ^ inv) == 1'b1) w++;
      got[b] = (w == t1);
      checks++;
      if (w != (expf[b] ? t1 : t0)) begin
        errors++;
        $display("[TB] FAIL pulse_width dut=%0d bit %0d got %0d cycles expected %0d",
                 i, b, w, expf[b] ? t1 : t0);
      end
    end
    checks++;
    if (got !== expf) begin
      errors++;
      $display("[TB] FAIL frame_decode dut=%0d got %h expected %h", i, got, expf);
    end
    rise = -1;
    for (int k = 1; k < flen; k++)
      if ((cap_line[k] ^ inv) && !(cap_line[k-1] ^ inv) && rise < 0) rise = k;
    checks++;
    if (rise != bc) begin
      errors++;
      $display("[TB] FAIL bit_period dut=%0d got %0d expected %0d", i, rise, bc);
    end
    ndone   = 0;
    done_at = -1;
    for (int k = 0; k < ncyc; k++)
      if (cap_done[k]) begin
        ndone++;
        if (done_at < 0) done_at = k;
      end
    checks++;
    if (ndone != 1 || done_at != flen - 1) begin
      errors++;
      $display("[TB] FAIL frame_done dut=%0d got %0d pulses first at %0d expected 1 at %0d",
               i, ndone, done_at, flen - 1);
    end
    blen = 0;
    while (blen < ncyc && cap_busy[blen]) blen++;
    checks++;
    if (blen != flen + GAP) begin
      errors++;
      $display("[TB] FAIL busy_length dut=%0d got %0d expected %0d", i, blen, flen + GAP);
    end
    rdy_bad = 0;
    for (int k = 0; k < flen + GAP; k++)
      if (cap_ready[k]) rdy_bad++;
    checks++;
    if (rdy_bad != 0 || cap_ready[flen + GAP] !== 1'b1) begin
      errors++;
      $display("[TB] FAIL ready_window dut=%0d got %0d ready cycles while busy, ready after=%b expected 0 and 1",
               i, rdy_bad, cap_ready[flen + GAP]);
    end
  endtask

  task automatic test_busy_drop;
    int flen, ncyc, bad, ndone, rdy_bad;
    logic [10:0] t;
    logic [15:0] expf;
    t    = 11'($urandom_range(2047));
    expf = model_frame(t, 1'b0, 1'b0);
    flen = 16 * BC_F;
    ncyc = flen + GAP + 40;
    capture(0, t, 1'b0, t ^ 11'h555, flen, ncyc);
    bad = -1;
    for (int k = 0; k < ncyc; k++)
      if (cap_line[k] !== model_active(expf, k, BC_F, T1_F, T0_F) && bad < 0) bad = k;
    checks++;
    if (bad >= 0) begin
      errors++;
      $display("[TB] FAIL drop_waveform cycle %0d got %b expected %b",
               bad, cap_line[bad], model_active(expf, bad, BC_F, T1_F, T0_F));
    end
    ndone   = 0;
    rdy_bad = 0;
    for (int k = 0; k < ncyc; k++) begin
      if (cap_done[k]) ndone++;
      if (k < flen + GAP && cap_ready[k]) rdy_bad++;
    end
    checks++;
    if (ndone != 1) begin
      errors++;
      $display("[TB] FAIL drop_frame_count got %0d expected 1", ndone);
    end
    checks++;
    if (rdy_bad != 0) begin
      errors++;
      $display("[TB] FAIL drop_ready got %0d ready cycles expected 0", rdy_bad);
    end
  endtask

  task automatic test_reset_mid;
    logic [10:0] t;
    int act_cnt, busy_cnt;
    t = 11'($urandom_range(2047));
    @(negedge clk);
    thr_v[0]   = t;
    telem_v[0] = 1'b0;
    valid_v[0] = 1'b1;
    @(negedge clk);
    valid_v[0] = 1'b0;
    repeat (8 * BC_F + 3) @(negedge clk);
    checks++;
    if (out_v[0] !== 1'b1) begin
      errors++;
      $display("[TB] FAIL bit7_active got %b expected 1", out_v[0]);
    end
    rst_v[0] = 1'b0;
    #1;
    checks++;
    if (out_v[0] !== 1'b0) begin
      errors++;
      $display("[TB] FAIL abort_line got %b expected 0", out_v[0]);
    end
    checks++;
    if (busy_v[0] !== 1'b0 || done_v[0] !== 1'b0) begin
      errors++;
      $display("[TB] FAIL abort_busy got busy=%b done=%b expected 0/0", busy_v[0], done_v[0]);
    end
    @(negedge clk);
    rst_v[0] = 1'b1;
    @(negedge clk);
    checks++;
    if (ready_v[0] !== 1'b1) begin
      errors++;
      $display("[TB] FAIL abort_ready got %b expected 1", ready_v[0]);
    end
    act_cnt  = 0;
    busy_cnt = 0;
    repeat (16 * BC_F + GAP) begin
      @(negedge clk);
      if (out_v[0]) act_cnt++;
      if (busy_v[0]) busy_cnt++;
    end
    checks++;
    if (act_cnt != 0 || busy_cnt != 0) begin
      errors++;
      $display("[TB] FAIL abort_residual got %0d active and %0d busy cycles expected 0/0", act_cnt, busy_cnt);
    end
  endtask

  task automatic test_repeat;
    int p, ncyc, bad, ndone, rdy_cnt;
    bit found;
    logic [15:0] expf;
    p    = 16 * BC_F + GAP;
    ncyc = 3 * p;
    expf = model_frame(11'd1046, 1'b0, 1'b0);
    capture(2, 11'd1046, 1'b0, 11'd1046, 0, ncyc);
    bad     = -1;
    ndone   = 0;
    rdy_cnt = 0;
    for (int k = 0; k < ncyc; k++) begin
      if (cap_line[k] !== model_active(expf, k % p, BC_F, T1_F, T0_F) && bad < 0) bad = k;
      if (cap_done[k]) ndone++;
      if (cap_ready[k]) rdy_cnt++;
    end
    checks++;
    if (bad >= 0) begin
      errors++;
      $display("[TB] FAIL repeat_waveform cycle %0d got %b expected %b",
               bad, cap_line[bad], model_active(expf, bad % p, BC_F, T1_F, T0_F));
    end
    checks++;
    if (ndone != 3 || rdy_cnt != 0) begin
      errors++;
      $display("[TB] FAIL repeat_frames got %0d frames %0d ready cycles expected 3 and 0", ndone, rdy_cnt);
    end
    // A new request waits out the current frame and gap, then replaces it.
    thr_v[2]   = 11'd48;
    telem_v[2] = 1'b0;
    valid_v[2] = 1'b1;
    found      = 1'b0;
    for (int n = 0; n < 2 * p; n++) begin
      @(negedge clk);
      if (ready_v[2]) begin
        found = 1'b1;
        break;
      end
    end
    checks++;
    if (!found) begin
      errors++;
      $display("[TB] FAIL repeat_accept_timeout got ready=0 for %0d cycles expected ready", 2 * p);
      valid_v[2] = 1'b0;
    end else begin
      expf = model_frame(11'd48, 1'b0, 1'b0);
      for (int k = 0; k < 2 * p; k++) begin
        @(negedge clk);
        cap_line[k] = out_v[2];
        valid_v[2]  = 1'b0;
      end
      bad = -1;
      for (int k = 0; k < 2 * p; k++)
        if (cap_line[k] !== model_active(expf, k % p, BC_F, T1_F, T0_F) && bad < 0) bad = k;
      checks++;
      if (bad >= 0) begin
        errors++;
        $display("[TB] FAIL repeat_new_frame frame %h cycle %0d got %b expected %b",
                 expf, bad, cap_line[bad], model_active(expf, bad % p, BC_F, T1_F, T0_F));
      end
    end
  endtask

  initial begin
    rst_v   = 4'h0;
    valid_v = 4'h0;
    telem_v = 4'h0;
    for (int i = 0; i < 4; i++) thr_v[i] = 11'd0;
    test_reset;
    test_frame(0, 11'd1046, 1'b0);
    test_frame(0, 11'd0, 1'b1);
    for (int r = 0; r < 3; r++)
      test_frame(0, 11'($urandom_range(2047)), 1'($urandom_range(1)));
    test_frame(1, 11'd0, 1'b1);
    for (int r = 0; r < 2; r++)
      test_frame(1, 11'($urandom_range(2047)), 1'($urandom_range(1)));
    test_busy_drop;
    test_reset_mid;
    test_frame(0, 11'($urandom_range(2047)), 1'($urandom_range(1)));
    test_frame(3, 11'd1046, 1'b0);
    test_frame(3, 11'($urandom_range(2047)), 1'($urandom_range(1)));
    test_repeat;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog got no completion expected finish before 100000 cycles");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/dshot_tx.md
DSHOT_TX -- requirements
Module: dshot_tx

Interface
REQ-001 SHALL have parameter CLK_HZ, default 16000000: input clock frequency in Hz.
REQ-002 SHALL have parameter BIT_RATE, default 600000: DShot bit rate in bit/s (150000, 300000, 600000 or 1200000).
REQ-003 SHALL have parameter GAP_CYC, default 64: minimum idle cycles between frames.
REQ-004 SHALL have parameter INVERTED, default 0: 1 selects bidirectional DShot (line idle high, pulses low, CRC inverted).
REQ-005 SHALL have parameter REPEAT, default 0: 1 retransmits the last accepted frame when no new request is pending.
REQ-006 SHALL have port CLK, input, 1 bit: the single clock; all logic on its rising edge.
REQ-007 SHALL have port rst_n, input, 1 bit: reset, asynchronous assert, active-low.
REQ-008 SHALL have port throttle, input, 11 bits: command/throttle value.
REQ-009 SHALL have port telem, input, 1 bit: telemetry request bit.
REQ-010 SHALL have port valid, input, 1 bit: request to send throttle/telem.
REQ-011 SHALL have port ready, output, 1 bit: block can accept a request this cycle.
REQ-012 SHALL have port dshot_out, output, 1 bit: serial DShot line.
REQ-013 SHALL have port busy, output, 1 bit: high while a frame or gap is in progress.
REQ-014 SHALL have port frame_done, output, 1 bit: one-cycle pulse on the last cycle of bit 0 of each frame.

Function
REQ-015 SHALL compute BIT_CYC = (CLK_HZ + BIT_RATE/2) / BIT_RATE, T1H = BIT_CYC*3/4 and T0H = BIT_CYC*3/8, all integer (27/20/10 at the defaults).
REQ-016 SHALL form v = {throttle, telem} (12 bits), crc = (v ^ v>>4 ^ v>>8) & 0xF, bitwise-inverted when INVERTED=1, and frame = {v, crc} (16 bits).
REQ-017 SHALL transmit frame MSB first; each bit lasts exactly BIT_CYC cycles and is active for T1H cycles when the bit is 1 or T0H cycles when it is 0, then inactive.
REQ-018 SHALL drive active as 1 and inactive as 0, swapped when INVERTED=1.
REQ-019 SHALL accept a request only on valid && ready, latching throttle/telem that cycle; ready is high only in IDLE.
REQ-020 SHALL make the first active cycle of bit 15 the cycle immediately after acceptance (latency 1).
REQ-021 SHALL run FSM IDLE -> SEND (16 bits) -> GAP (GAP_CYC cycles) -> IDLE.
REQ-022 SHALL, at the end of GAP with REPEAT=1 and no valid, restart SEND with the held frame, bypassing IDLE; valid seen in IDLE always takes priority.
REQ-023 SHALL keep busy = (state != IDLE).
REQ-024 SHALL ignore valid while busy, dropping it, and SHALL NOT alter the frame in flight.
REQ-025 SHALL use a bit counter that wraps 15 -> done (no 17th bit) and a cycle counter that wraps BIT_CYC-1 -> 0.

Reset
REQ-026 SHALL, while rst_n is low, force state = IDLE, ready = 1 (after release), busy = 0, frame_done = 0, dshot_out = inactive level, held frame = 0, counters = 0.
REQ-027 SHALL abort a frame on reset mid-SEND, return dshot_out to inactive immediately, and never resume the aborted frame.

Structure
REQ-028 SHALL place the CRC function, the 16-bit frame type, and the BIT_CYC/T1H/T0H derivation in package dshot_pkg.
REQ-029 SHALL implement the per-bit cycle counter and high/low compare as sub-module dshot_bit_timer (inputs: start, bit value; outputs: line level, bit_end).

Verification
REQ-030 SHALL check defaults, throttle=1046, telem=0: frame 0x82C6, 16 bits of 27 cycles each, high widths 20/10 per bit, frame_done once, busy for 432+64 cycles.
REQ-031 SHALL check throttle=0, telem=1: frame 0x0011; INVERTED=1 gives frame 0x001E, idle high, low pulses.
REQ-032 SHALL check valid held high during SEND: only one frame sent, second request dropped, ready=0 throughout.
REQ-033 SHALL check REPEAT=1, single request 0x82C6: back-to-back identical frames separated by exactly 64 idle cycles; a new valid=1046->48 after a gap is transmitted next.
REQ-034 SHALL check rst_n pulled low at bit 7: dshot_out inactive the same cycle, after release ready=1 and no residual bits.
REQ-035 SHALL check BIT_RATE=150000: BIT_CYC=107, T1H=80, T0H=40 measured on the line.
